// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the direct-mapped cache controller.
//   coherency_t  : per-line state, encoded to match memory_subsystem
//                  (I=2'b00, M=2'b01, S=2'b10)
//   ctrl_state_t : controller FSM states
//   ADDR_W       : word address width on both CPU and memory sides
//   line_valid() : true when a line holds usable data (S or M)
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W = 14;

  typedef enum logic [1:0] {
    COH_I = 2'b00,
    COH_M = 2'b01,
    COH_S = 2'b10
  } coherency_t;

  // ST_WRITE_THRU is only reachable in the write-through build.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_WRITEBACK  = 3'd2,
    ST_FILL       = 3'd3,
    ST_RESPOND    = 3'd4,
    ST_WRITE_THRU = 3'd5
  } ctrl_state_t;

  function automatic logic line_valid(input coherency_t st);
    return (st == COH_S) || (st == COH_M);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// -----------------------------------------------------------------------------
// cache_line_store
// Data / tag / coherency-state arrays for a direct-mapped, one-word-per-line
// cache. One combinational read port, one synchronous write port. Reset
// clears only the state array (all lines to I); data and tags are left as-is
// because an I line is never consulted.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   rd_idx                   read index
//   rd_data, rd_tag, rd_state  contents of line rd_idx
//   wr_en, wr_idx            write strobe and index
//   wr_data, wr_tag, wr_state  values written into line wr_idx
// -----------------------------------------------------------------------------
module cache_line_store
  import cache_pkg::*;
#(
  parameter int DATA_SIZE = 2,
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = ADDR_W - IDX_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [DATA_SIZE*8-1:0] rd_data,
  output logic [TAG_W-1:0]       rd_tag,
  output coherency_t             rd_state,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [DATA_SIZE*8-1:0] wr_data,
  input  logic [TAG_W-1:0]       wr_tag,
  input  coherency_t             wr_state
);

  logic [DATA_SIZE*8-1:0] data_mem  [NUM_LINES];
  logic [TAG_W-1:0]       tag_mem   [NUM_LINES];
  coherency_t             state_mem [NUM_LINES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        state_mem[i] <= COH_I;
      end
    end else if (wr_en) begin
      state_mem[wr_idx] <= wr_state;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_data;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

  assign rd_data  = data_mem[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_state = state_mem[rd_idx];

endmodule

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
// Direct-mapped, one-word-per-line cache between a CPU port and
// memory_subsystem. Write-back / write-allocate by default.
// Build option: define CACHE_WRITE_THROUGH_EN to make every write also write
// the word to memory before cpu_ready; lines then never become M and the
// WRITEBACK state is never entered.
// Parameters: DATA_SIZE (bytes per word), NUM_LINES (power of two, 2..64).
// Ports:
//   clk, reset_n                       clock, synchronous active-low reset
//   cpu_req, cpu_we, cpu_addr, cpu_wdata  CPU request (captured in IDLE)
//   cpu_rdata, cpu_ready               read data, one-cycle completion pulse
//   processor_req                      memory request, held until processor_resp
//   mem_read_req, mem_write_req        memory op select (mutually exclusive)
//   addr, mem_write_data               memory word address, writeback data
//   mem_read_data, processor_resp      fill data, memory completion
// -----------------------------------------------------------------------------
module cache_controller
  import cache_pkg::*;
#(
  parameter int DATA_SIZE = 2,
  parameter int NUM_LINES = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_SIZE*8-1:0] cpu_wdata,
  output logic [DATA_SIZE*8-1:0] cpu_rdata,
  output logic                   cpu_ready,
  output logic                   processor_req,
  output logic                   mem_read_req,
  output logic                   mem_write_req,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_SIZE*8-1:0] mem_write_data,
  input  logic [DATA_SIZE*8-1:0] mem_read_data,
  input  logic                   processor_resp
);

  localparam int DW    = DATA_SIZE * 8;
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  // State a line takes after a write, and where a write goes after the
  // line is updated.
`ifdef CACHE_WRITE_THROUGH_EN
  localparam coherency_t  WRITE_LINE_STATE = COH_S;
  localparam ctrl_state_t AFTER_WRITE      = ST_WRITE_THRU;
`else
  localparam coherency_t  WRITE_LINE_STATE = COH_M;
  localparam ctrl_state_t AFTER_WRITE      = ST_RESPOND;
`endif

  ctrl_state_t state, next_state;

  // Captured request
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DW-1:0]     req_wdata;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  // Line store interface
  logic [DW-1:0]     line_data;
  logic [TAG_W-1:0]  line_tag;
  coherency_t        line_state;
  logic              line_hit;
  logic              st_wr_en;
  logic [DW-1:0]     st_wr_data;
  coherency_t        st_wr_state;

  // Datapath strobes from the FSM
  logic              rdata_load;
  logic [DW-1:0]     rdata_next;
  logic              mem_issue;
  logic              mem_issue_we;
  logic [ADDR_W-1:0] mem_issue_addr;
  logic [DW-1:0]     mem_issue_data;
  logic              mem_clear;

  assign req_idx  = req_addr[IDX_W-1:0];
  assign req_tag  = req_addr[ADDR_W-1:IDX_W];
  assign line_hit = line_valid(line_state) && (line_tag == req_tag);

  cache_line_store #(
    .DATA_SIZE (DATA_SIZE),
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (req_idx),
    .rd_data  (line_data),
    .rd_tag   (line_tag),
    .rd_state (line_state),
    .wr_en    (st_wr_en),
    .wr_idx   (req_idx),
    .wr_data  (st_wr_data),
    .wr_tag   (req_tag),
    .wr_state (st_wr_state)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Memory states issue their request on the first edge they see
  // processor_req low; since the previous request is cleared on the edge
  // that leaves a memory state, processor_req always idles for at least
  // one cycle between consecutive requests.
  always_comb begin
    next_state     = state;
    st_wr_en       = 1'b0;
    st_wr_data     = line_data;
    st_wr_state    = line_state;
    rdata_load     = 1'b0;
    rdata_next     = line_data;
    mem_issue      = 1'b0;
    mem_issue_we   = 1'b0;
    mem_issue_addr = req_addr;
    mem_issue_data = req_wdata;
    mem_clear      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cpu_req) next_state = ST_LOOKUP;
      end

      ST_LOOKUP: begin
        if (line_hit) begin
          rdata_load = 1'b1;
          if (req_we) begin
            st_wr_en    = 1'b1;
            st_wr_data  = req_wdata;
            st_wr_state = WRITE_LINE_STATE;
            rdata_next  = req_wdata;
            next_state  = AFTER_WRITE;
          end else begin
            next_state  = ST_RESPOND;
          end
        end else if (line_state == COH_M) begin
          next_state = ST_WRITEBACK;
        end else begin
          next_state = ST_FILL;
        end
      end

      ST_WRITEBACK: begin
        if (!processor_req) begin
          mem_issue      = 1'b1;
          mem_issue_we   = 1'b1;
          mem_issue_addr = {line_tag, req_idx};
          mem_issue_data = line_data;
        end else if (processor_resp) begin
          mem_clear  = 1'b1;
          next_state = ST_FILL;
        end
      end

      ST_FILL: begin
        if (!processor_req) begin
          mem_issue = 1'b1;
        end else if (processor_resp) begin
          mem_clear  = 1'b1;
          st_wr_en   = 1'b1;
          rdata_load = 1'b1;
          if (req_we) begin
            // Write-allocate: the filled word is immediately overwritten.
            st_wr_data  = req_wdata;
            st_wr_state = WRITE_LINE_STATE;
            rdata_next  = req_wdata;
            next_state  = AFTER_WRITE;
          end else begin
            st_wr_data  = mem_read_data;
            st_wr_state = COH_S;
            rdata_next  = mem_read_data;
            next_state  = ST_RESPOND;
          end
        end
      end

      ST_WRITE_THRU: begin
        if (!processor_req) begin
          mem_issue    = 1'b1;
          mem_issue_we = 1'b1;
        end else if (processor_resp) begin
          mem_clear  = 1'b1;
          next_state = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        next_state = ST_IDLE;
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cpu_req) begin
      req_addr  <= cpu_addr;
      req_we    <= cpu_we;
      req_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      processor_req  <= 1'b0;
      mem_read_req   <= 1'b0;
      mem_write_req  <= 1'b0;
      addr           <= '0;
      mem_write_data <= '0;
      cpu_rdata      <= '0;
    end else begin
      if (mem_issue) begin
        processor_req <= 1'b1;
        mem_read_req  <= ~mem_issue_we;
        mem_write_req <= mem_issue_we;
        addr          <= mem_issue_addr;
        if (mem_issue_we) mem_write_data <= mem_issue_data;
      end else if (mem_clear) begin
        processor_req <= 1'b0;
        mem_read_req  <= 1'b0;
        mem_write_req <= 1'b0;
      end
      if (rdata_load) cpu_rdata <= rdata_next;
    end
  end

  assign cpu_ready = (state == ST_RESPOND);

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

`ifdef CACHE_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        processor_req;
  logic        mem_read_req;
  logic        mem_write_req;
  logic [13:0] addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        processor_resp;

  int tests_run = 0;
  int tests_failed = 0;

  // Results of the last do_access
  logic [15:0] r_rdata;
  int          r_lat, r_nrd, r_nwr, r_req_cyc;
  logic [13:0] r_rd_addr, r_wr_addr;
  logic [15:0] r_wr_data;
  bit          r_first_wr, r_both, r_unstable, r_gap, r_timeout;

  cache_controller #(.DATA_SIZE(2), .NUM_LINES(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ready      (cpu_ready),
    .processor_req  (processor_req),
    .mem_read_req   (mem_read_req),
    .mem_write_req  (mem_write_req),
    .addr           (addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .processor_resp (processor_resp)
  );

  always #5 clk = ~clk;

  // One CPU access with the bench acting as memory. delay = cycles the
  // memory waits (with processor_req seen high) before answering.
  task automatic do_access(input logic we, input logic [13:0] a, input logic [15:0] wd,
                           input logic [15:0] mem_rd, input int delay, input bit toggle,
                           input bit no_gap);
    int cyc, wait_cnt;
    bit in_req, resp_pending, got_ready;
    logic [13:0] h_addr;
    logic [15:0] h_data;
    logic h_rd, h_wr;
    r_rdata = 16'hxxxx; r_lat = -1; r_nrd = 0; r_nwr = 0; r_req_cyc = 0;
    r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0;
    r_first_wr = 0; r_both = 0; r_unstable = 0; r_gap = 0; r_timeout = 0;
    h_addr = '0; h_data = '0; h_rd = 0; h_wr = 0;
    if (!no_gap) begin @(posedge clk); #1; end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    cyc = 0; wait_cnt = 0; in_req = 0; resp_pending = 0; got_ready = 0;
    while (cyc < 200 && !got_ready) begin
      @(posedge clk); #1; cyc++;
      if (resp_pending) begin
        processor_resp = 1'b0; resp_pending = 0; in_req = 0;
        if (processor_req) r_gap = 1;
      end else if (processor_req) begin
        r_req_cyc++;
        if (mem_read_req && mem_write_req) r_both = 1;
        if (!in_req) begin
          in_req = 1; wait_cnt = 0;
          h_addr = addr; h_data = mem_write_data; h_rd = mem_read_req; h_wr = mem_write_req;
          if (mem_write_req) begin
            r_nwr++; r_wr_addr = addr; r_wr_data = mem_write_data;
            if (r_nrd == 0) r_first_wr = 1;
          end else if (mem_read_req) begin
            r_nrd++; r_rd_addr = addr;
          end
        end else if (addr !== h_addr || mem_write_data !== h_data ||
                     mem_read_req !== h_rd || mem_write_req !== h_wr) begin
          r_unstable = 1;
        end
        if (wait_cnt >= delay) begin
          processor_resp = 1'b1; mem_read_data = mem_rd; resp_pending = 1;
        end
        wait_cnt++;
      end
      if (cpu_ready) begin
        got_ready = 1; r_rdata = cpu_rdata; r_lat = cyc;
      end else if (toggle) begin
        cpu_req = ~cpu_req; cpu_addr = 14'h3FFF; cpu_we = ~cpu_we;
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    processor_resp = 1'b0;
    if (!got_ready) r_timeout = 1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    mem_read_data = '0; processor_resp = 0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (cpu_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_cpu_ready: got %b want 0", cpu_ready); end
    tests_run++; if (processor_req !== 1'b0) begin tests_failed++; $display("FAIL rst_processor_req: got %b want 0", processor_req); end
    tests_run++; if ({mem_read_req, mem_write_req} !== 2'b00) begin tests_failed++; $display("FAIL rst_mem_ops: got %b want 00", {mem_read_req, mem_write_req}); end
    tests_run++; if (addr !== 14'h0) begin tests_failed++; $display("FAIL rst_addr: got %h want 0", addr); end
    tests_run++; if (mem_write_data !== 16'h0) begin tests_failed++; $display("FAIL rst_wdata: got %h want 0", mem_write_data); end
    tests_run++; if (cpu_rdata !== 16'h0) begin tests_failed++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
    reset_n = 1'b1;
  endtask

  task automatic test_read_miss_fill();
    do_access(1'b0, 14'h0010, 16'h0, 16'h0011, 0, 0, 0);
    tests_run++; if (r_rdata !== 16'h0011) begin tests_failed++; $display("FAIL fill_rdata: got %h want 0011", r_rdata); end
    tests_run++; if (r_nrd !== 1 || r_nwr !== 0) begin tests_failed++; $display("FAIL fill_ops: got rd=%0d wr=%0d want rd=1 wr=0", r_nrd, r_nwr); end
    tests_run++; if (r_rd_addr !== 14'h0010) begin tests_failed++; $display("FAIL fill_addr: got %h want 0010", r_rd_addr); end
  endtask

  task automatic test_read_hit();
    do_access(1'b0, 14'h0010, 16'h0, 16'hDEAD, 0, 0, 0);
    tests_run++; if (r_rdata !== 16'h0011) begin tests_failed++; $display("FAIL hit_rdata: got %h want 0011", r_rdata); end
    tests_run++; if (r_lat !== 2) begin tests_failed++; $display("FAIL hit_latency: got %0d want 2", r_lat); end
    tests_run++; if (r_req_cyc !== 0) begin tests_failed++; $display("FAIL hit_traffic: got %0d req cycles want 0", r_req_cyc); end
  endtask

  task automatic test_write_hit();
    do_access(1'b1, 14'h0010, 16'hBEEF, 16'hDEAD, 0, 0, 0);
    tests_run++; if (r_nwr !== (WT ? 1 : 0) || r_nrd !== 0) begin tests_failed++; $display("FAIL whit_ops: got rd=%0d wr=%0d want rd=0 wr=%0d", r_nrd, r_nwr, WT ? 1 : 0); end
    tests_run++; if (r_wr_data !== (WT ? 16'hBEEF : 16'h0)) begin tests_failed++; $display("FAIL whit_mem_data: got %h want %h", r_wr_data, WT ? 16'hBEEF : 16'h0); end
    do_access(1'b0, 14'h0010, 16'h0, 16'hDEAD, 0, 0, 0);
    tests_run++; if (r_rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL whit_readback: got %h want BEEF", r_rdata); end
    tests_run++; if (r_req_cyc !== 0) begin tests_failed++; $display("FAIL whit_readback_traffic: got %0d want 0", r_req_cyc); end
  endtask

  task automatic test_evict_writeback();
    do_access(1'b0, 14'h0018, 16'h0, 16'h5A5A, 0, 0, 0);
    tests_run++; if (r_nwr !== (WT ? 0 : 1)) begin tests_failed++; $display("FAIL evict_wr_count: got %0d want %0d", r_nwr, WT ? 0 : 1); end
    tests_run++; if (r_wr_addr !== (WT ? 14'h0 : 14'h0010) || r_wr_data !== (WT ? 16'h0 : 16'hBEEF)) begin tests_failed++; $display("FAIL evict_wr: got %h/%h want %h/%h", r_wr_addr, r_wr_data, WT ? 14'h0 : 14'h0010, WT ? 16'h0 : 16'hBEEF); end
    tests_run++; if (r_first_wr !== !WT) begin tests_failed++; $display("FAIL evict_order: got write_first=%0b want %0b", r_first_wr, !WT); end
    tests_run++; if (r_nrd !== 1 || r_rd_addr !== 14'h0018) begin tests_failed++; $display("FAIL evict_fill: got rd=%0d addr=%h want 1/0018", r_nrd, r_rd_addr); end
    tests_run++; if (r_rdata !== 16'h5A5A) begin tests_failed++; $display("FAIL evict_rdata: got %h want 5A5A", r_rdata); end
    tests_run++; if (r_both !== 0 || r_gap !== 0) begin tests_failed++; $display("FAIL evict_handshake: got both=%0b gap_err=%0b want 0/0", r_both, r_gap); end
    // Victim now S: straight to FILL
    do_access(1'b0, 14'h0010, 16'h0, 16'h0BAD, 0, 0, 0);
    tests_run++; if (r_nwr !== 0 || r_nrd !== 1) begin tests_failed++; $display("FAIL clean_evict_ops: got rd=%0d wr=%0d want 1/0", r_nrd, r_nwr); end
    tests_run++; if (r_rdata !== 16'h0BAD) begin tests_failed++; $display("FAIL clean_evict_rdata: got %h want 0BAD", r_rdata); end
  endtask

  task automatic test_write_miss();
    do_access(1'b1, 14'h0021, 16'h7777, 16'h1111, 0, 0, 0);
    tests_run++; if (r_nrd !== 1 || r_rd_addr !== 14'h0021) begin tests_failed++; $display("FAIL wmiss_fill: got rd=%0d addr=%h want 1/0021", r_nrd, r_rd_addr); end
    tests_run++; if (r_nwr !== (WT ? 1 : 0) || r_wr_data !== (WT ? 16'h7777 : 16'h0)) begin tests_failed++; $display("FAIL wmiss_wr: got wr=%0d data=%h want %0d/%h", r_nwr, r_wr_data, WT ? 1 : 0, WT ? 16'h7777 : 16'h0); end
    do_access(1'b0, 14'h0021, 16'h0, 16'hDEAD, 0, 0, 0);
    tests_run++; if (r_rdata !== 16'h7777 || r_req_cyc !== 0) begin tests_failed++; $display("FAIL wmiss_merge: got %h req=%0d want 7777/0", r_rdata, r_req_cyc); end
    do_access(1'b0, 14'h0029, 16'h0, 16'h2929, 0, 0, 0);
    tests_run++; if (r_nwr !== (WT ? 0 : 1) || r_wr_addr !== (WT ? 14'h0 : 14'h0021) || r_wr_data !== (WT ? 16'h0 : 16'h7777)) begin tests_failed++; $display("FAIL wmiss_evict: got wr=%0d %h/%h", r_nwr, r_wr_addr, r_wr_data); end
    tests_run++; if (r_rdata !== 16'h2929) begin tests_failed++; $display("FAIL wmiss_evict_rdata: got %h want 2929", r_rdata); end
  endtask

  task automatic test_write_through();
    do_access(1'b1, 14'h0003, 16'h1234, 16'h0000, 0, 0, 0);
    tests_run++; if (r_nwr !== (WT ? 1 : 0) || r_wr_addr !== (WT ? 14'h0003 : 14'h0) || r_wr_data !== (WT ? 16'h1234 : 16'h0)) begin tests_failed++; $display("FAIL wt_write: got wr=%0d %h/%h", r_nwr, r_wr_addr, r_wr_data); end
    do_access(1'b0, 14'h000B, 16'h0, 16'h0B0B, 0, 0, 0);
    tests_run++; if (r_nwr !== (WT ? 0 : 1) || r_wr_data !== (WT ? 16'h0 : 16'h1234)) begin tests_failed++; $display("FAIL wt_evict: got wr=%0d data=%h want %0d/%h", r_nwr, r_wr_data, WT ? 0 : 1, WT ? 16'h0 : 16'h1234); end
    tests_run++; if (r_rdata !== 16'h0B0B) begin tests_failed++; $display("FAIL wt_evict_rdata: got %h want 0B0B", r_rdata); end
  endtask

  task automatic test_delayed_resp();
    do_access(1'b0, 14'h0035, 16'h0, 16'hC35C, 5, 1, 0);
    tests_run++; if (r_req_cyc !== 6) begin tests_failed++; $display("FAIL slow_req_cycles: got %0d want 6", r_req_cyc); end
    tests_run++; if (r_unstable !== 0) begin tests_failed++; $display("FAIL slow_stable: got unstable=%0b want 0", r_unstable); end
    tests_run++; if (r_rdata !== 16'hC35C || r_nrd !== 1 || r_rd_addr !== 14'h0035) begin tests_failed++; $display("FAIL slow_fill: got %h rd=%0d addr=%h want C35C/1/0035", r_rdata, r_nrd, r_rd_addr); end
    do_access(1'b0, 14'h0035, 16'h0, 16'hDEAD, 0, 0, 0);
    tests_run++; if (r_rdata !== 16'hC35C || r_req_cyc !== 0) begin tests_failed++; $display("FAIL slow_rehit: got %h req=%0d want C35C/0", r_rdata, r_req_cyc); end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 14'h0035, 16'h0, 16'hDEAD, 0, 0, 0);
    do_access(1'b0, 14'h0035, 16'h0, 16'hDEAD, 0, 0, 1);
    tests_run++; if (r_rdata !== 16'hC35C || r_req_cyc !== 0) begin tests_failed++; $display("FAIL b2b_hit: got %h req=%0d want C35C/0", r_rdata, r_req_cyc); end
    tests_run++; if (r_lat !== 3) begin tests_failed++; $display("FAIL b2b_latency: got %0d want 3", r_lat); end
    do_access(1'b1, 14'h0035, 16'h5151, 16'hDEAD, 0, 0, 1);
    do_access(1'b0, 14'h0035, 16'h0, 16'hDEAD, 0, 0, 1);
    tests_run++; if (r_rdata !== 16'h5151 || r_req_cyc !== 0) begin tests_failed++; $display("FAIL b2b_wr_rd: got %h req=%0d want 5151/0", r_rdata, r_req_cyc); end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    do_access(1'b1, 14'h0026, 16'h4444, 16'h0000, 0, 0, 0);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0024; cpu_wdata = '0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (processor_req && mem_read_req) seen = 1;
    end
    cpu_req = 1'b0;
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL rmid_fill_started: got %0b want 1", seen); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    tests_run++; if ({cpu_ready, processor_req, mem_read_req, mem_write_req} !== 4'b0000) begin tests_failed++; $display("FAIL rmid_ctrl: got %b want 0000", {cpu_ready, processor_req, mem_read_req, mem_write_req}); end
    tests_run++; if (addr !== 14'h0 || mem_write_data !== 16'h0 || cpu_rdata !== 16'h0) begin tests_failed++; $display("FAIL rmid_data: got %h/%h/%h want 0/0/0", addr, mem_write_data, cpu_rdata); end
    reset_n = 1'b1;
    do_access(1'b0, 14'h0024, 16'h0, 16'h2424, 0, 0, 0);
    tests_run++; if (r_nrd !== 1 || r_rdata !== 16'h2424) begin tests_failed++; $display("FAIL rmid_remiss: got rd=%0d %h want 1/2424", r_nrd, r_rdata); end
    do_access(1'b0, 14'h002E, 16'h0, 16'h2E2E, 0, 0, 0);
    tests_run++; if (r_nwr !== 0 || r_nrd !== 1) begin tests_failed++; $display("FAIL rmid_no_wb: got rd=%0d wr=%0d want 1/0", r_nrd, r_nwr); end
    do_access(1'b0, 14'h0010, 16'h0, 16'h1010, 0, 0, 0);
    tests_run++; if (r_nrd !== 1 || r_rdata !== 16'h1010) begin tests_failed++; $display("FAIL rmid_invalidated: got rd=%0d %h want 1/1010", r_nrd, r_rdata); end
  endtask

  initial begin
    test_reset();
    test_read_miss_fill();
    test_read_hit();
    test_write_hit();
    test_evict_writeback();
    test_write_miss();
    test_write_through();
    test_delayed_resp();
    test_back_to_back();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL: DATA_SIZE, 2, data width in bytes (bus width DATA_SIZE*8).
REQ-002 SHALL: NUM_LINES, 8, number of direct-mapped lines (power of two, 2..64).
REQ-003 SHALL: clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL: reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL: cpu_req  in  1  processor access request, held until cpu_ready.
REQ-006 SHALL: cpu_we  in  1  1=write, 0=read, valid with cpu_req.
REQ-007 SHALL: cpu_addr  in  14  word address.
REQ-008 SHALL: cpu_wdata  in  DATA_SIZE*8  write data.
REQ-009 SHALL: cpu_rdata  out  DATA_SIZE*8  read data, valid while cpu_ready=1.
REQ-010 SHALL: cpu_ready  out  1  single-cycle completion pulse.
REQ-011 SHALL: processor_req  out  1  memory-side request to memory_subsystem.
REQ-012 SHALL: mem_read_req / mem_write_req  out  1 each  memory operation select, mutually exclusive.
REQ-013 SHALL: addr  out  14  memory word address.
REQ-014 SHALL: mem_write_data  out  DATA_SIZE*8  writeback data.
REQ-015 SHALL: mem_read_data  in  DATA_SIZE*8  fill data, sampled when processor_resp=1.
REQ-016 SHALL: processor_resp  in  1  memory completion.

Function
REQ-017 SHALL: direct-mapped, one word per line; index=cpu_addr[log2(NUM_LINES)-1:0], tag=remaining upper bits; per-line state I/S/M.
REQ-018 SHALL: FSM states IDLE, LOOKUP, WRITEBACK, FILL, RESPOND; request captured (addr, we, wdata registered) when cpu_req=1 in IDLE.
REQ-019 SHALL: LOOKUP hit (tag match, state S or M): read returns line data, cpu_ready in the cycle after LOOKUP (2 cycles after capture); return to IDLE.
REQ-020 SHALL: write hit updates line data, line state becomes M, no memory traffic.
REQ-021 SHALL: miss with victim M -> WRITEBACK (write victim word to victim address), then FILL; miss with victim I or S -> FILL directly.
REQ-022 SHALL: memory handshake: processor_req plus exactly one op and addr/mem_write_data held stable until processor_resp sampled 1; processor_req deasserted the following cycle for at least one cycle.
REQ-023 SHALL: FILL loads mem_read_data, line state S, then RESPOND; a write miss then merges cpu_wdata and sets M (write-allocate).
REQ-024 SHALL: cpu_req during non-IDLE states ignored; cpu_ready never asserted outside RESPOND / hit completion.
REQ-025 SHALL: processor_resp outside WRITEBACK/FILL ignored; no timeout.
REQ-026 SHALL: cpu_req with same address immediately after cpu_ready is a new access (hit).

Reset
REQ-027 SHALL: reset_n=0 sampled: all line states I, FSM IDLE, cpu_ready, processor_req, mem_read_req, mem_write_req =0, addr, mem_write_data, cpu_rdata =0.
REQ-028 SHALL: reset mid-transaction aborts it immediately; no writeback of M lines; processor_req drops the next edge.

Configuration
REQ-029 SHALL: CACHE_WRITE_THROUGH_EN defined: every write (hit or miss) also issues a memory write of the word via the REQ-022 handshake before cpu_ready; lines never enter M; WRITEBACK state unreachable.
REQ-030 SHALL: CACHE_WRITE_THROUGH_EN undefined: write-back behaviour of REQ-020..REQ-023.

Structure
REQ-031 SHALL: package cache_pkg holds coherency_t (I=2'b00, M=2'b01, S=2'b10, matching memory_subsystem encoding), FSM state enum, ADDR_W=14.
REQ-032 SHALL: sub-module cache_line_store holds data/tag/state arrays, one read port, one write port, synchronous write, reset clears states only.

Verification
REQ-033 SHALL: read 0x0010 after reset, memory returns 0x0011 -> FILL issued, cpu_rdata=0x0011, line S; repeat read -> hit, cpu_ready 2 cycles after capture, no processor_req.
REQ-034 SHALL: write 0xBEEF to 0x0010 (line S) -> no memory traffic, line M; read 0x0010 -> 0xBEEF.
REQ-035 SHALL: then read 0x0018 (same index, NUM_LINES=8) -> memory write addr 0x0010 data 0xBEEF, then read 0x0018, mem_read_req/mem_write_req never both 1.
REQ-036 SHALL: processor_resp delayed 5 cycles -> processor_req, addr, data stable all 5 cycles; cpu_req toggling meanwhile ignored.
REQ-037 SHALL: reset_n low during FILL -> next cycle all outputs 0, subsequent read of same address misses.
REQ-038 SHALL: CACHE_WRITE_THROUGH_EN build, write 0x1234 to 0x0003 -> memory write issued before cpu_ready, line state never M.
